regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester round-robin write-back arbiter for a
// register file, with an initialisation sweep that writes register i with
// value i. Every register-file write passes through one pipeline stage.
// Optional feature macro: ZERO_REG_PROTECT_EN (handshakes to register 0 are
// accepted but never written).
module regfile_wb_arbiter #(
  parameter int ADDR = 5,
  parameter int SIZE = 32
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Init_Start,
  input  logic            A_Valid,
  input  logic [ADDR-1:0] A_Addr,
  input  logic [SIZE-1:0] A_Data,
  output logic            A_Ready,
  input  logic            B_Valid,
  input  logic [ADDR-1:0] B_Addr,
  input  logic [SIZE-1:0] B_Data,
  output logic            B_Ready,
  output logic            Write_Reg,
  output logic [ADDR-1:0] W_Addr,
  output logic [SIZE-1:0] W_Data,
  output logic            Busy,
  output logic            Init_Done
);

  typedef enum logic {
    ST_INIT,
    ST_ARB
  } state_t;

  state_t          state, state_nxt;
  logic [ADDR-1:0] cnt;        // sweep index being presented
  logic            prio_b;     // 1: B wins the next tie (A was granted last)
  logic            done_q;     // registered Init_Done pulse
  logic            wr_q;
  logic [ADDR-1:0] waddr_q;
  logic [SIZE-1:0] wdata_q;

  logic            sweep_wr;   // a sweep write is presented this cycle
  logic            arb_open;   // arbitration allowed this cycle
  logic            grant_a;
  logic            grant_b;
  logic            a_wr_ok;    // granted A write actually reaches the file
  logic            b_wr_ok;

  // Next-state, grant and sweep-presentation decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_nxt = state;
    sweep_wr  = 1'b0;
    arb_open  = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    a_wr_ok   = 1'b1;
    b_wr_ok   = 1'b1;

    // Once the final sweep write is issued (done_q), nothing new is presented
    // and the FSM moves to arbitration on the following edge.
    case (state)
      ST_INIT: begin
        sweep_wr = !done_q;
        if (done_q) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        arb_open = !Init_Start && !Clr;
        if (Init_Start) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_INIT;
    endcase

    // Round-robin: a lone requester always wins; on a tie the pointer decides.
    grant_a = arb_open && A_Valid && (!B_Valid || !prio_b);
    grant_b = arb_open && B_Valid && (!A_Valid ||  prio_b);

`ifdef ZERO_REG_PROTECT_EN
    a_wr_ok = (A_Addr != '0);
    b_wr_ok = (B_Addr != '0);
`else
    a_wr_ok = 1'b1;
    b_wr_ok = 1'b1;
`endif
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Clr) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Sweep counter, priority pointer and Init_Done pulse.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      cnt    <= '0;
      prio_b <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // The counter wraps to zero after the last index, so it is already
      // at 0 when a later Init_Start re-enters the sweep.
      if (sweep_wr)                           cnt <= cnt + 1'b1;
      else if (state == ST_ARB && Init_Start) cnt <= '0;

      if (grant_a)      prio_b <= 1'b1;
      else if (grant_b) prio_b <= 1'b0;

      done_q <= sweep_wr && (cnt == '1);
    end
  end

  // Write pipeline: one cycle from presentation/handshake to the file port.
  always_ff @(posedge Clk) begin
    // NOTE: only these control/pipeline flops need reset; the register file itself lives outside.
    if (Clr) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (sweep_wr) begin
      wr_q    <= 1'b1;
      waddr_q <= cnt;
      wdata_q <= SIZE'(cnt);
    end else if (grant_a && a_wr_ok) begin
      wr_q    <= 1'b1;
      waddr_q <= A_Addr;
      wdata_q <= A_Data;
    end else if (grant_b && b_wr_ok) begin
      wr_q    <= 1'b1;
      waddr_q <= B_Addr;
      wdata_q <= B_Data;
    end else begin
      wr_q    <= 1'b0;
    end
  end

  assign A_Ready   = grant_a;
  assign B_Ready   = grant_b;
  assign Write_Reg = wr_q;
  assign W_Addr    = waddr_q;
  assign W_Data    = wdata_q;
  assign Busy      = (state == ST_INIT) || Clr;
  assign Init_Done = done_q;

endmodule
